// File: rtl/pipe_regfile.sv
// Register file with combinational write-bypass reads and a busy-bit scoreboard
// that tracks destinations issued but not yet written back.
module pipe_regfile #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned NR = 3
) (
    input  logic             PCclk,
    input  logic             rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic             RegWrite,
    input  logic [AW-1:0]    regW,
    input  logic [DW-1:0]    Wdat,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_reg,
    output logic             stall,
    output logic [AW:0]      busy_cnt
);

    localparam int unsigned NREG    = 2 ** AW;
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(NREG - 1);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    logic wb_fire_c;
    logic iss_fire_c;
    logic set_new_c;
    logic clr_real_c;

    // Register 0 is hardwired to zero, so neither path may target it.
    assign wb_fire_c  = RegWrite && (regW != '0);
    assign iss_fire_c = iss_valid && (iss_reg != '0);

    // Popcount deltas: a same-register issue/writeback pair resolves to the
    // issue, so the clear never counts in that case.
    assign set_new_c  = iss_fire_c && !busy_q[iss_reg];
    assign clr_real_c = wb_fire_c && busy_q[regW] &&
                        !(iss_fire_c && (iss_reg == regW));

    always_comb begin
        regs_d = regs_q;
        if (wb_fire_c) begin
            regs_d[regW] = Wdat;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_fire_c) begin
            busy_d[regW] = 1'b0;
        end
        if (iss_fire_c) begin
            busy_d[iss_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (set_new_c && !clr_real_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (clr_real_c && !set_new_c && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge PCclk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port read: zero register, then same-cycle writeback bypass, then array.
    for (genvar i = 0; i < int'(NR); i++) begin : g_rd
        logic [AW-1:0] addr_c;
        logic          byp_c;

        assign addr_c = rd_addr[i*AW +: AW];
        assign byp_c  = wb_fire_c && (addr_c == regW);

        assign rd_data[i*DW +: DW] = (addr_c == '0) ? '0 :
                                     byp_c          ? Wdat :
                                                      regs_q[addr_c];
        assign rd_busy[i] = !byp_c && busy_q[addr_c];
    end

    assign stall    = |rd_busy;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Randomized and directed check of pipe_regfile against an array-based model.
module tb_pipe_regfile;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NR   = 3;
    localparam int unsigned NREG = 32;

    logic             PCclk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             RegWrite;
    logic [AW-1:0]    regW;
    logic [DW-1:0]    Wdat;
    logic             iss_valid;
    logic [AW-1:0]    iss_reg;
    logic             stall;
    logic [AW:0]      busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_busy [NREG];

    pipe_regfile #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .PCclk    (PCclk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .RegWrite (RegWrite),
        .regW     (regW),
        .Wdat     (Wdat),
        .iss_valid(iss_valid),
        .iss_reg  (iss_reg),
        .stall    (stall),
        .busy_cnt (busy_cnt)
    );

    always #5 PCclk = ~PCclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < int'(NREG); r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic logic [DW-1:0] port_data(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic set_idle();
        RegWrite  = 1'b0;
        regW      = '0;
        Wdat      = '0;
        iss_valid = 1'b0;
        iss_reg   = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(NREG); r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Expected read outputs from the model state plus the live writeback.
    task automatic check_comb();
        logic          any_busy;
        logic [AW-1:0] a;
        logic          byp;
        logic [DW-1:0] exp_d;
        logic          exp_b;
        any_busy = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            a     = rd_addr[i*AW +: AW];
            byp   = RegWrite && (regW != 0) && (a == regW);
            exp_d = (a == 0) ? '0 : (byp ? Wdat : m_regs[a]);
            exp_b = (a != 0) && !byp && m_busy[a];
            any_busy = any_busy | exp_b;
            check($sformatf("rd_data%0d a=%0d", i, a), 64'(port_data(i)), 64'(exp_d));
            check($sformatf("rd_busy%0d a=%0d", i, a), 64'(rd_busy[i]), 64'(exp_b));
        end
        check("stall", 64'(stall), 64'(any_busy));
    endtask

    // Check the pre-edge outputs, clock once, apply the rules to the model, check the count.
    task automatic cycle();
        #2;
        check_comb();
        @(posedge PCclk);
        if (rst) begin
            model_reset();
        end else begin
            if (RegWrite && regW != 0) begin
                m_regs[regW] = Wdat;
                m_busy[regW] = 1'b0;
            end
            if (iss_valid && iss_reg != 0) m_busy[iss_reg] = 1'b1;
        end
        #1;
        check("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        set_idle();
        set_rd(0, 0, 0);
        model_reset();
        repeat (2) @(posedge PCclk);
        #1;
        check("reset_cnt", 64'(busy_cnt), 64'd0);
        set_rd(1, 18, 31);
        #2;
        check("reset_rd2", 64'(port_data(2)), 64'd0);
        check("reset_busy", 64'(rd_busy), 64'd0);
        cycle();

        // Write 18, read 16/17/18 after the edge
        rst = 1'b0;
        RegWrite = 1'b1; regW = 5'd18; Wdat = 32'hAAAABBBB;
        set_rd(16, 17, 18);
        cycle();
        set_idle();
        #2;
        check("w18_p2", 64'(port_data(2)), 64'hAAAABBBB);
        check("w18_p0", 64'(port_data(0)), 64'd0);
        check("w18_p1", 64'(port_data(1)), 64'd0);

        // Same-cycle bypass
        RegWrite = 1'b1; regW = 5'd5; Wdat = 32'h12345678;
        set_rd(5, 18, 0);
        #2;
        check("bypass_d", 64'(port_data(0)), 64'h12345678);
        check("bypass_b", 64'(rd_busy[0]), 64'd0);
        cycle();

        // Register 0 discards writes
        RegWrite = 1'b1; regW = 5'd0; Wdat = 32'hFFFFFFFF;
        set_rd(0, 0, 0);
        cycle();
        set_idle();
        #2;
        check("r0_p0", 64'(port_data(0)), 64'd0);
        check("r0_cnt", 64'(busy_cnt), 64'd0);

        // Issue 7, then issue 9 with writeback 7
        iss_valid = 1'b1; iss_reg = 5'd7;
        set_rd(7, 9, 0);
        cycle();
        set_idle();
        #2;
        check("iss7_busy", 64'(rd_busy[0]), 64'd1);
        check("iss7_stall", 64'(stall), 64'd1);
        check("iss7_cnt", 64'(busy_cnt), 64'd1);
        iss_valid = 1'b1; iss_reg = 5'd9;
        RegWrite = 1'b1; regW = 5'd7; Wdat = 32'h00000777;
        cycle();
        set_idle();
        #2;
        check("swap_cnt", 64'(busy_cnt), 64'd1);
        check("swap_b7", 64'(rd_busy[0]), 64'd0);
        check("swap_b9", 64'(rd_busy[1]), 64'd1);

        // Issue and writeback the same register: issue wins
        iss_valid = 1'b1; iss_reg = 5'd3;
        RegWrite = 1'b1; regW = 5'd3; Wdat = 32'hCAFEF00D;
        set_rd(3, 9, 7);
        cycle();
        set_idle();
        #2;
        check("same3_d", 64'(port_data(0)), 64'hCAFEF00D);
        check("same3_b", 64'(rd_busy[0]), 64'd1);
        check("same3_cnt", 64'(busy_cnt), 64'd2);

        // Fill the scoreboard, then reset mid-flight
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int r = 1; r < int'(NREG); r++) begin
            iss_valid = 1'b1; iss_reg = AW'(r);
            set_rd(r, rnd_addr(), 0);
            cycle();
        end
        set_idle();
        #2;
        check("fill_cnt", 64'(busy_cnt), 64'd31);
        rst = 1'b1;
        iss_valid = 1'b1; iss_reg = 5'd4;
        RegWrite = 1'b1; regW = 5'd12; Wdat = 32'h0BADBEEF;
        cycle();
        rst = 1'b0;
        set_idle();
        set_rd(18, 5, 3);
        #2;
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_busy", 64'(rd_busy), 64'd0);
        set_rd(12, 31, 4);
        #2;
        check("rst_data2", 64'(rd_data), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            RegWrite  = ($urandom_range(0, 1) == 1);
            regW      = AW'(rnd_addr());
            Wdat      = DW'($urandom());
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_reg   = AW'(rnd_addr());
            set_rd(rnd_addr(), rnd_addr(), ($urandom_range(0, 1) == 1) ? int'(regW) : rnd_addr());
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
